// File: rtl/montre_de1_timer_array_if.sv
// Register-bus bundle for montre_de1_timer_array: 16-bit single-port slave plus irq.
interface montre_de1_timer_array_if #(
  parameter int AW = 5
);
  logic [AW-1:0] address;
  logic          chipselect;
  logic          write_n;
  logic [15:0]   writedata;
  logic [15:0]   readdata;
  logic          irq;

  modport master (output address, chipselect, write_n, writedata, input readdata, irq);
  modport slave  (input address, chipselect, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/montre_de1_timer_array.sv
// Array of NUM_CH independent down-counting timers behind a 16-bit register bus.
// Define TIMER_ARRAY_PRESCALER_EN to add a per-channel 16-bit tick prescaler at offset 6.
module montre_de1_timer_array #(
  parameter int          NUM_CH     = 4,
  parameter int          CNT_W      = 32,
  parameter logic [31:0] DEF_PERIOD = 32'h02FA_F07F
) (
  input  logic                    clk,
  input  logic                    reset_n,
  montre_de1_timer_array_if.slave bus
);
  localparam int AW = 3 + $clog2(NUM_CH);
  localparam int HW = CNT_W - 16;
  localparam logic [CNT_W-1:0] DEF_CNT = DEF_PERIOD[CNT_W-1:0];

  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [CNT_W-1:0]  per_q [NUM_CH];
  logic [CNT_W-1:0]  per_d [NUM_CH];
  logic [CNT_W-1:0]  snap_q[NUM_CH];
  logic [CNT_W-1:0]  snap_d[NUM_CH];
  logic [3:0]        ctrl_q[NUM_CH];
  logic [3:0]        ctrl_d[NUM_CH];
  logic [NUM_CH-1:0] to_q, to_d, run_q, run_d, nz_q, nz_d;
  logic [NUM_CH-1:0] wr_ch, force_reload, start, stop, evt, tick;
`ifdef TIMER_ARRAY_PRESCALER_EN
  logic [15:0]       presc_q[NUM_CH];
  logic [15:0]       presc_d[NUM_CH];
  logic [15:0]       pcnt_q [NUM_CH];
  logic [15:0]       pcnt_d [NUM_CH];
`endif
  logic [15:0]       readdata_q, readdata_d;
  logic [AW-1:0]     ch_sel;
  logic [2:0]        off;
  logic              wr, ch_ok, irq_w;

  assign ch_sel = bus.address >> 3;
  assign off    = bus.address[2:0];
  assign ch_ok  = ch_sel < AW'(NUM_CH);
  assign wr     = bus.chipselect & ~bus.write_n;

  always_comb begin
    wr_ch        = '0;
    force_reload = '0;
    start        = '0;
    stop         = '0;
    evt          = '0;
    tick         = '0;
    to_d         = to_q;
    run_d        = run_q;
    nz_d         = nz_q;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_ch[i]        = wr && ch_ok && (ch_sel == AW'(i));
      force_reload[i] = wr_ch[i] && (off == 3'd2 || off == 3'd3);
      start[i]        = wr_ch[i] && (off == 3'd1) && bus.writedata[2];
      stop[i]         = wr_ch[i] && (off == 3'd1) && bus.writedata[3];
      // Edge on reaching zero, so a parked zero counter does not re-flag.
      evt[i]          = (cnt_q[i] == '0) && nz_q[i];
      nz_d[i]         = (cnt_q[i] != '0);

`ifdef TIMER_ARRAY_PRESCALER_EN
      presc_d[i] = presc_q[i];
      tick[i]    = (pcnt_q[i] == '0);
      if (wr_ch[i] && off == 3'd6) begin
        presc_d[i] = bus.writedata;
        pcnt_d[i]  = bus.writedata;
      end else if (tick[i]) begin
        pcnt_d[i]  = presc_q[i];
      end else begin
        pcnt_d[i]  = pcnt_q[i] - 16'd1;
      end
`else
      tick[i] = 1'b1;
`endif

      per_d[i] = per_q[i];
      if (wr_ch[i] && off == 3'd2) per_d[i][15:0]      = bus.writedata;
      if (wr_ch[i] && off == 3'd3) per_d[i][CNT_W-1:16] = bus.writedata[HW-1:0];

      ctrl_d[i] = (wr_ch[i] && off == 3'd1) ? bus.writedata[3:0] : ctrl_q[i];
      snap_d[i] = (wr_ch[i] && (off == 3'd4 || off == 3'd5)) ? cnt_q[i] : snap_q[i];
      to_d[i]   = evt[i] | (to_q[i] & ~(wr_ch[i] && off == 3'd0));

      if (start[i])
        run_d[i] = 1'b1;
      else if (stop[i] || force_reload[i] || (cnt_q[i] == '0 && !ctrl_q[i][1]))
        run_d[i] = 1'b0;

      // Reload at zero in both modes so a finished one-shot parks at its period.
      cnt_d[i] = cnt_q[i];
      if (force_reload[i])
        cnt_d[i] = per_d[i];
      else if (run_q[i] && tick[i])
        cnt_d[i] = (cnt_q[i] == '0) ? per_q[i] : cnt_q[i] - CNT_W'(1);
    end
  end

  always_comb begin
    readdata_d = '0;
    irq_w      = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      irq_w = irq_w | (to_q[i] & ctrl_q[i][0]);
      if (ch_ok && ch_sel == AW'(i)) begin
        case (off)
          3'd0:    readdata_d = {14'd0, run_q[i], to_q[i]};
          3'd1:    readdata_d = {12'd0, ctrl_q[i]};
          3'd2:    readdata_d = per_q[i][15:0];
          3'd3:    readdata_d = 16'(per_q[i][CNT_W-1:16]);
          3'd4:    readdata_d = snap_q[i][15:0];
          3'd5:    readdata_d = 16'(snap_q[i][CNT_W-1:16]);
`ifdef TIMER_ARRAY_PRESCALER_EN
          3'd6:    readdata_d = presc_q[i];
`else
          3'd6:    readdata_d = 16'd0;
`endif
          default: readdata_d = 16'(to_q);
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]   <= DEF_CNT;
        per_q[i]   <= DEF_CNT;
        snap_q[i]  <= '0;
        ctrl_q[i]  <= '0;
`ifdef TIMER_ARRAY_PRESCALER_EN
        presc_q[i] <= '0;
        pcnt_q[i]  <= '0;
`endif
      end
      to_q       <= '0;
      run_q      <= '0;
      nz_q       <= '0;
      readdata_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]   <= cnt_d[i];
        per_q[i]   <= per_d[i];
        snap_q[i]  <= snap_d[i];
        ctrl_q[i]  <= ctrl_d[i];
`ifdef TIMER_ARRAY_PRESCALER_EN
        presc_q[i] <= presc_d[i];
        pcnt_q[i]  <= pcnt_d[i];
`endif
      end
      to_q       <= to_d;
      run_q      <= run_d;
      nz_q       <= nz_d;
      readdata_q <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign bus.irq      = irq_w;
endmodule

// File: doc/montre_de1_timer_array.md
MONTRE_DE1_TIMER_ARRAY -- requirements
Module: montre_de1_timer_array

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent timer channels (1..8).
REQ-002 Parameter CNT_W, default 32, counter width in bits (17..32); period/snapshot high words hold bits CNT_W-1:16, zero-extended on read.
REQ-003 Parameter DEF_PERIOD, default 32'h2FAF07F, reset value of every channel's period and counter (truncated to CNT_W).
REQ-004 Port clk, input, 1: single clock for all logic.
REQ-005 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 Port address, input, 3+clog2(NUM_CH): bits [2:0] register offset, upper bits channel index.
REQ-007 Port chipselect, input, 1: slave select.
REQ-008 Port write_n, input, 1: active-low write strobe.
REQ-009 Port writedata, input, 16: write data.
REQ-010 Port readdata, output, 16: registered read data.
REQ-011 Port irq, output, 1: OR over channels of (TO & ITO).

Function
REQ-012 Write = chipselect & ~write_n, decoded per channel; a channel index >= NUM_CH is ignored and reads 0.
REQ-013 Offset 0 STATUS: bit0 TO, bit1 RUN (read-only); any write clears TO.
REQ-014 Offset 1 CONTROL: bits[3:0] stored; bit0 ITO, bit1 CONT; writedata[2] START and writedata[3] STOP act as single-cycle strobes.
REQ-015 Offsets 2/3 PERIOD_L/H; offsets 4/5 SNAP_L/H; offset 6 PRESCALE; offset 7 PENDING (read-only, bit i = TO of channel i, same value from every channel slot).
REQ-016 readdata is updated every cycle from the addressed register, so a read has 1-cycle latency; it is independent of chipselect.
REQ-017 Counter decrements by 1 on each tick while RUN=1; at 0 with RUN=1 it reloads {PERIOD_H,PERIOD_L} on the next tick.
REQ-018 Writing PERIOD_L or PERIOD_H sets force_reload for one cycle, which loads the counter from the period registers and clears RUN.
REQ-019 RUN: START sets it; otherwise STOP, force_reload, or (counter==0 & CONT=0) clears it; START wins when START and a clear condition coincide.
REQ-020 Timeout event = counter==0 now & counter!=0 on the previous cycle; it sets TO.
REQ-021 A timeout event and a STATUS write in the same cycle leave TO=1; events are never lost.
REQ-022 A SNAP_L or SNAP_H write copies the live counter into the snapshot register in that cycle.
REQ-023 Channels are fully independent; simultaneous writes to different channels are impossible by the single-port protocol.

Reset
REQ-024 On reset_n=0, asynchronously: counter and period = DEF_PERIOD; CONTROL, TO, RUN, snapshot, PRESCALE, prescale counter, readdata = 0; irq = 0.
REQ-025 Reset mid-count aborts the count immediately; after release the channel is stopped until START.

Configuration
REQ-026 Macro TIMER_ARRAY_PRESCALER_EN defined: per-channel 16-bit PRESCALE; a tick occurs once every PRESCALE+1 clocks; a PRESCALE write restarts the prescale counter.
REQ-027 Macro TIMER_ARRAY_PRESCALER_EN undefined: tick = every clk, offset 6 reads 0, and writes to offset 6 are ignored.

Verification
REQ-028 Reset, read ch0 PERIOD_L/H -> 0xF07F/0x02FA; STATUS -> 0x0000; irq=0.
REQ-029 ch1: PERIOD=5, CONTROL=0x0005 (START|ITO, one-shot) -> TO rises 6 cycles after START; RUN=0; irq=1; PENDING=0x0002; STATUS write -> irq=0.
REQ-030 ch2: PERIOD=3, CONTROL=0x0006 (continuous) -> timeout every 4 cycles; STOP write -> counter holds; SNAP_L write then read returns the frozen value.
REQ-031 STATUS write in the same cycle as a timeout event -> TO stays 1.
REQ-032 With the macro defined, ch0 PRESCALE=2, PERIOD=2, START -> TO after 9 cycles; without the macro, offset 6 reads 0.
REQ-033 PERIOD_L write while ch3 is running -> RUN=0 next cycle, counter = new period; ch0-2 are unaffected.
